ddr_tx_serializer: RTL
======================

Name: ddr_tx_serializer

Overview:
Word-to-pair gearbox directly upstream of the O_DDR output primitive. Accepts WORD_W-bit words over a valid/ready handshake and emits one 2-bit pair per CLK on DDR_D/DDR_E, which drive O_DDR D[1:0]/E. A one-word prefetch buffer lets back-to-back words stream with no idle gap. Idle and underrun conditions are flagged.

Parameters:
WORD_W, 8, input word width; must be even and >= 4; BEATS = WORD_W/2 pairs per word.
IDLE_PAIR, 2'b00, value driven on DDR_D whenever no data is being sent.
LSB_FIRST, 1, 1: pair order word[1:0] first; 0: word[WORD_W-1:WORD_W-2] first.

Ports:
CLK  input  1  single clock; all state updates on posedge.
RST_N  input  1  asynchronous, active-low reset.
IN_DATA  input  WORD_W  word to serialize.
IN_LAST  input  1  word ends a burst; qualifies underrun detection.
IN_VALID  input  1  IN_DATA/IN_LAST valid.
IN_READY  output  1  block can accept a word this cycle.
DDR_D  output  2  pair to O_DDR D; registered.
DDR_E  output  1  pair valid / O_DDR enable; registered.
BUSY  output  1  state is SHIFT.
UNDERRUN  output  1  one-cycle pulse: non-last word finished with no successor available.

Behaviour:
- Reset (RST_N low, async): state IDLE, DDR_D=IDLE_PAIR, DDR_E=0, UNDERRUN=0, BUSY=0, buf_valid=0, cnt=0, so IN_READY=1. Reset mid-word drops the word and any buffered word without completing them.
- IN_READY = !buf_valid, combinational from the register. Accept = IN_VALID && IN_READY.
- State: sreg (shift register), cnt (pairs emitted for the current word, 1..BEATS), cur_last, and buf/buf_last/buf_valid.
- IDLE: on accept, at the same edge: DDR_D <= first pair, DDR_E <= 1, sreg <= the remaining pairs, cnt <= 1, cur_last <= IN_LAST, state <= SHIFT. Latency is 1 cycle from the accept edge to the first pair on DDR_D. With no accept, DDR_D stays IDLE_PAIR and DDR_E stays 0.
- SHIFT, cnt < BEATS: each edge emits the next pair, DDR_E=1, cnt++. An accept in this phase loads buf, with buf_valid <= 1.
- SHIFT, cnt == BEATS (last pair of the word on DDR_D), at the next edge, in priority order:
  1. buf_valid: load buf as the new word (first pair out, cnt <= 1), buf_valid <= 0. IN_READY was 0, so no simultaneous accept.
  2. Else if accept: load IN_DATA directly as the new word. Buf stays empty.
  3. Else: DDR_D <= IDLE_PAIR, DDR_E <= 0, state <= IDLE. If cur_last == 0, UNDERRUN <= 1 for exactly one cycle; otherwise UNDERRUN stays 0.
- Sustained throughput is 1 word per BEATS cycles. DDR_E has no gap between consecutive words when the next word arrives by the final pair's cycle.
- UNDERRUN defaults to 0 every cycle unless set as above.
- BUSY = (state == SHIFT).
- IN_VALID must hold its data until accepted. Data is unconstrained when IN_VALID=0.

Test Plan:
- Reset then single word, WORD_W=8, IN_DATA=8'hB4, IN_LAST=1: over 4 cycles DDR_D = 00, 01, 11, 10 with DDR_E=1 starting 1 cycle after accept. Then DDR_D=00, DDR_E=0, UNDERRUN stays 0. With LSB_FIRST=0 the order is 10, 11, 01, 00.
- Back-to-back words 8'hB4 then 8'h1E (last=1) with IN_VALID held: 8 contiguous DDR_E=1 cycles, pairs 00,01,11,10,10,11,01,00. IN_READY drops to 0 while buf holds 8'h1E.
- Word 8'hFF with IN_LAST=0 and no successor: 4 pairs of 11, then DDR_E falls and UNDERRUN=1 for exactly one cycle.
- Successor presented exactly in the final-pair cycle with buf empty: loaded directly, no DDR_E gap, buf_valid never set.
- Assert RST_N low asynchronously mid-word, e.g. after 2 pairs with buf full: DDR_E=0, DDR_D=IDLE_PAIR and IN_READY=1 immediately. After release, a new word 8'h0F streams 11, 11, 00, 00.
- Random valid/ready backpressure over 1000 words, compared against a reference model: every word serialized in order, no pair lost or duplicated.

Source files
------------

// File: rtl/ddr_tx_serializer.sv
// ---------------------------------------------------------------------------
// ddr_tx_serializer
//
// Word-to-pair gearbox feeding an O_DDR output primitive. Words arrive over a
// valid/ready handshake and leave as one 2-bit pair per clock on DDR_D, with
// DDR_E marking valid pairs. A one-word prefetch buffer lets consecutive
// words stream with no idle cycle between them. An UNDERRUN pulse flags a
// non-last word that ran out with nothing queued behind it.
//
// Parameters:
//   WORD_W     input word width, even and >= 4 (BEATS = WORD_W/2 pairs)
//   IDLE_PAIR  value held on DDR_D whenever no data is being sent
//   LSB_FIRST  1: word[1:0] leaves first; 0: word[WORD_W-1:WORD_W-2] first
//
// Ports:
//   CLK       single clock, all state updates on the rising edge
//   RST_N     asynchronous active-low reset
//   IN_DATA   word to serialize
//   IN_LAST   word ends a burst (suppresses UNDERRUN after it)
//   IN_VALID  IN_DATA/IN_LAST valid
//   IN_READY  block can accept a word this cycle
//   DDR_D     pair to O_DDR D[1:0], registered
//   DDR_E     pair valid / O_DDR enable, registered
//   BUSY      a word is being shifted out
//   UNDERRUN  one-cycle pulse: non-last word finished with no successor
// ---------------------------------------------------------------------------
module ddr_tx_serializer #(
    parameter int unsigned WORD_W    = 8,
    parameter logic [1:0]  IDLE_PAIR = 2'b00,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [WORD_W-1:0] IN_DATA,
    input  logic              IN_LAST,
    input  logic              IN_VALID,
    output logic              IN_READY,
    output logic [1:0]        DDR_D,
    output logic              DDR_E,
    output logic              BUSY,
    output logic              UNDERRUN
);

    localparam int unsigned BEATS = WORD_W / 2;
    localparam int unsigned CNT_W = $clog2(BEATS + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // -----------------------------------------------------------------------
    // Pair extraction helpers. The shift register always presents the next
    // pair at the same end, so the direction of the shift follows LSB_FIRST.
    // -----------------------------------------------------------------------
    function automatic logic [1:0] head_pair(input logic [WORD_W-1:0] w);
        if (LSB_FIRST) begin
            return w[1:0];
        end
        return w[WORD_W-1 -: 2];
    endfunction

    function automatic logic [WORD_W-1:0] tail_bits(input logic [WORD_W-1:0] w);
        if (LSB_FIRST) begin
            return w >> 2;
        end
        return w << 2;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [0:0]        state_q,     state_d;
    logic [WORD_W-1:0] sreg_q,      sreg_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              cur_last_q,  cur_last_d;
    logic [WORD_W-1:0] buf_q,       buf_d;
    logic              buf_last_q,  buf_last_d;
    logic              buf_valid_q, buf_valid_d;
    logic [1:0]        ddr_d_q,     ddr_d_d;
    logic              ddr_e_q,     ddr_e_d;
    logic              underrun_q,  underrun_d;

    // Word selected for loading into the shifter this cycle, if any.
    logic              load_en;
    logic [WORD_W-1:0] load_word;
    logic              load_last;

    logic              accept;
    logic              last_beat;

    // Ready depends only on the buffer register, so there is no combinational
    // path from IN_VALID back to IN_READY.
    assign IN_READY  = !buf_valid_q;
    assign accept    = IN_VALID && IN_READY;
    assign last_beat = (cnt_q == CNT_W'(BEATS));

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so
        // no path through the case statement can infer a latch.
        state_d     = state_q;
        sreg_d      = sreg_q;
        cnt_d       = cnt_q;
        cur_last_d  = cur_last_q;
        buf_d       = buf_q;
        buf_last_d  = buf_last_q;
        buf_valid_d = buf_valid_q;
        ddr_d_d     = IDLE_PAIR;
        ddr_e_d     = 1'b0;
        underrun_d  = 1'b0;
        load_en     = 1'b0;
        load_word   = IN_DATA;
        load_last   = IN_LAST;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    load_en = 1'b1;
                end
            end

            ST_SHIFT: begin
                if (!last_beat) begin
                    // Mid-word: emit the next pair; an arriving word parks in
                    // the prefetch buffer.
                    ddr_d_d = head_pair(sreg_q);
                    ddr_e_d = 1'b1;
                    sreg_d  = tail_bits(sreg_q);
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (accept) begin
                        buf_d       = IN_DATA;
                        buf_last_d  = IN_LAST;
                        buf_valid_d = 1'b1;
                    end
                end else if (buf_valid_q) begin
                    // Buffered word wins; IN_READY is low so no accept can
                    // collide with it.
                    load_en     = 1'b1;
                    load_word   = buf_q;
                    load_last   = buf_last_q;
                    buf_valid_d = 1'b0;
                end else if (accept) begin
                    // Successor arrived exactly in the final-pair cycle:
                    // bypass the buffer so DDR_E stays high.
                    load_en = 1'b1;
                end else begin
                    state_d    = ST_IDLE;
                    underrun_d = !cur_last_q;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Common word load: first pair goes straight to the output register,
        // the remaining pairs stay in the shifter.
        if (load_en) begin
            ddr_d_d    = head_pair(load_word);
            ddr_e_d    = 1'b1;
            sreg_d     = tail_bits(load_word);
            cnt_d      = CNT_W'(1);
            cur_last_d = load_last;
            state_d    = ST_SHIFT;
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            // NOTE: the word datapath (sreg, buf) is reset along with control
            // so that nothing undefined can reach the pad after reset, even
            // though buf_valid/cnt already mark it as don't-care.
            state_q     <= ST_IDLE;
            sreg_q      <= '0;
            cnt_q       <= '0;
            cur_last_q  <= 1'b0;
            buf_q       <= '0;
            buf_last_q  <= 1'b0;
            buf_valid_q <= 1'b0;
            ddr_d_q     <= IDLE_PAIR;
            ddr_e_q     <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values computed above, independent of order.
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            cnt_q       <= cnt_d;
            cur_last_q  <= cur_last_d;
            buf_q       <= buf_d;
            buf_last_q  <= buf_last_d;
            buf_valid_q <= buf_valid_d;
            ddr_d_q     <= ddr_d_d;
            ddr_e_q     <= ddr_e_d;
            underrun_q  <= underrun_d;
        end
    end

    assign DDR_D    = ddr_d_q;
    assign DDR_E    = ddr_e_q;
    assign UNDERRUN = underrun_q;
    assign BUSY     = (state_q == ST_SHIFT);

endmodule
